skintone_result_collector: RTL and testbench
============================================

Name: skintone_result_collector

Overview:
- Receiving end of the skintone datapath result stream.
- Accepts 8-bit results (valid-only, no backpressure) and packs four results into a 32-bit word.
- Buffers packed words in a word FIFO and presents them downstream with a valid/ready handshake.
- Issues pixel credits back to the pixel feeder, so the datapath is never fed a pixel that cannot be stored when it emerges.

Parameters:
- FIFO_DEPTH, 8: number of 32-bit words in the output FIFO; power of 2, at least 2.
- CNT_W, 6: width of the credit and in-flight counters; must hold 4*FIFO_DEPTH.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- pixel_issue  in  1  feeder asserted pixel_datain_valid this cycle
- issue_allow  out  1  feeder may issue a pixel this cycle
- result_datain  in  8  result byte from datapath
- result_datain_valid  in  1  result byte valid
- flush  in  1  emit partial word (macro-gated)
- word_dataout  out  32  packed word; first result in [7:0]
- word_bytes  out  3  valid bytes in word_dataout, 1..4
- word_dataout_valid  out  1  FIFO head valid
- word_dataout_ready  in  1  downstream accepts head
- idle  out  1  inflight==0 and pack_cnt==0 and FIFO empty
- err  out  1  sticky protocol error

Behaviour:
- Reset (async, while rst=1):
  - pack_cnt=0, inflight=0, FIFO empty, err=0.
  - Outputs: word_dataout_valid=0, issue_allow=1, idle=1, word_dataout=0, word_bytes=0.
- Credit accounting:
  - committed = 4*fifo_count + pack_cnt + inflight, computed from current registers.
  - issue_allow = (committed < 4*FIFO_DEPTH); combinational.
  - The feeder asserts pixel_issue only when issue_allow=1.
- inflight update each edge:
  - +1 on pixel_issue.
  - -1 on result_datain_valid.
  - Both in the same cycle: unchanged.
- Packing:
  - Each valid byte is stored in byte lane pack_cnt; pack_cnt increments.
  - When pack_cnt==3 and a valid byte arrives, {byte, pack_reg[23:0]} is written to the FIFO at that same edge with word_bytes=4, and pack_cnt returns to 0.
  - Latency: 4th byte sampled at edge k, so word_dataout_valid=1 from after edge k (if FIFO was empty).
- FIFO:
  - First-word-fall-through; the head is visible while word_dataout_valid=1.
  - Pop on valid&&ready.
  - Push and pop in the same cycle when full: legal, count unchanged.
  - Pointers wrap modulo FIFO_DEPTH; one extra pointer bit distinguishes full from empty.
- Stability: word_dataout and word_bytes hold stable while valid&&!ready.
- err conditions (sticky until rst):
  - result_datain_valid with inflight==0 (underflow). The byte is still packed if space exists.
  - A byte needs a FIFO slot while the FIFO is full with no same-cycle pop (overflow). The word is dropped and pack_cnt still returns to 0.
  - pixel_issue while issue_allow=0.
- Reset mid-operation: all buffered data is discarded and the block returns to its reset state immediately.

Optional Feature:
- Macro: SKINTONE_COLLECT_FLUSH_EN.
- Defined:
  - flush is sampled each edge. It is legal only when inflight==0 and result_datain_valid==0.
  - If legal and pack_cnt>0: the partial word (unused upper lanes = 0) is pushed with word_bytes=pack_cnt, and pack_cnt returns to 0.
  - If legal and pack_cnt==0: no effect.
  - flush while inflight!=0 or with a same-cycle valid byte is ignored and sets err.
  - Space is guaranteed by the credit rule.
- Undefined: the flush port is present but ignored; word_bytes is always 4.

Decomposition:
- Shared package: word width 32, byte width 8, lanes-per-word 4, and the err cause encoding (UNDERFLOW, OVERFLOW, ISSUE_VIOL), also used by the feeder.
- One sub-module: skintone_word_fifo, a parameterised FWFT FIFO with count output. The packer and credit logic stay in the top.

Test Plan:
- Issue 4 pixels; bytes 0x11,0x22,0x33,0x44 arrive 16 cycles later on consecutive cycles. Required: word_dataout=0x44332211, word_bytes=4, valid one cycle after 0x44, idle=1 after pop.
- FIFO_DEPTH=8, word_dataout_ready=0, feeder issues whenever allowed. Required: exactly 32 issues, then issue_allow=0; no err; 8 words held stable.
- With the FIFO full, assert ready for 1 cycle. Required: one pop, and issue_allow=1 for exactly 4 further issues.
- Simultaneous pixel_issue and result byte every cycle for 64 cycles, ready=1. Required: inflight constant, 16 words out in order, err=0.
- With the macro defined, 3 bytes 0xAA,0xBB,0xCC, then flush with inflight=0. Required: word 0x00CCBBAA, word_bytes=3. Flush with inflight=2: ignored, err=1.
- Byte with inflight=0: err=1 and the byte is packed. Assert rst mid-word: valid=0, idle=1, err=0 immediately.

Source files
------------

// File: rtl/skintone_result_collector_pkg.sv
// rtl/skintone_result_collector_pkg.sv - shared widths, FIFO entry layout and error cause encoding
// Also imported by the pixel feeder for the err cause encoding.
package skintone_result_collector_pkg;

  localparam int WORD_W  = 32;
  localparam int BYTE_W  = 8;
  localparam int LANES   = 4;
  localparam int BYTES_W = 3;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'd0,
    ERR_UNDERFLOW  = 2'd1,
    ERR_OVERFLOW   = 2'd2,
    ERR_ISSUE_VIOL = 2'd3
  } err_cause_e;

  typedef struct packed {
    logic [BYTES_W-1:0] bytes;
    logic [WORD_W-1:0]  data;
  } fifo_entry_t;

  // Keeps byte lanes below n, clears the rest (partial-word emission).
  function automatic logic [WORD_W-1:0] lane_mask(input logic [1:0] n);
    logic [WORD_W-1:0] m;
    m = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i < int'(n)) m[i*BYTE_W +: BYTE_W] = '1;
    end
    return m;
  endfunction

endpackage

// File: rtl/skintone_word_fifo.sv
// rtl/skintone_word_fifo.sv - parameterised first-word-fall-through FIFO with occupancy count
// Push while full is accepted only when a pop happens in the same cycle.
module skintone_word_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 35
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head_data,
  output logic                     head_valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop && head_valid;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign count      = wr_ptr - rd_ptr;
  assign head_valid = (count != '0);
  assign full       = (count == (AW+1)'(DEPTH));
  assign head_data  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/skintone_result_collector.sv
// rtl/skintone_result_collector.sv - packs datapath result bytes into words and issues pixel credits
// Optional partial-word flush is enabled by defining SKINTONE_COLLECT_FLUSH_EN.
module skintone_result_collector
  import skintone_result_collector_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pixel_issue,
  output logic              issue_allow,
  input  logic [BYTE_W-1:0] result_datain,
  input  logic              result_datain_valid,
  input  logic              flush,
  output logic [WORD_W-1:0] word_dataout,
  output logic [2:0]        word_bytes,
  output logic              word_dataout_valid,
  input  logic              word_dataout_ready,
  output logic              idle,
  output logic              err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = CNT_W + 2;

  logic [CNT_W-1:0] inflight;
  logic [1:0]       pack_cnt;
  logic [23:0]      pack_reg;
  logic [AW:0]      fifo_count;
  logic             fifo_full;
  logic             fifo_valid;
  logic             fifo_push;
  logic             fifo_pop;
  fifo_entry_t      push_entry;
  fifo_entry_t      head_entry;
  logic [CW-1:0]    committed;
  logic             word_done;
  logic             flush_push;
  logic             flush_bad;
  logic [3:0]       err_hit;

  // Every pixel in flight, every packed byte and every buffered word holds a byte slot.
  assign committed   = (CW'(fifo_count) << 2) + CW'(pack_cnt) + CW'(inflight);
  assign issue_allow = (committed < CW'(LANES * FIFO_DEPTH));

  assign word_done = result_datain_valid && (pack_cnt == 2'd3);
  assign fifo_pop  = fifo_valid && word_dataout_ready;

`ifdef SKINTONE_COLLECT_FLUSH_EN
  assign flush_bad  = flush && ((inflight != '0) || result_datain_valid);
  assign flush_push = flush && !flush_bad && (pack_cnt != 2'd0);
`else
  assign flush_bad  = flush & 1'b0;
  assign flush_push = 1'b0;
`endif

  always_comb begin
    push_entry = '0;
    fifo_push  = 1'b0;
    if (word_done) begin
      fifo_push        = 1'b1;
      push_entry.data  = {result_datain, pack_reg};
      push_entry.bytes = 3'd4;
    end else if (flush_push) begin
      fifo_push        = 1'b1;
      push_entry.data  = {8'h00, pack_reg} & lane_mask(pack_cnt);
      push_entry.bytes = {1'b0, pack_cnt};
    end
  end

  always_comb begin
    err_hit                 = '0;
    err_hit[ERR_UNDERFLOW]  = result_datain_valid && (inflight == '0);
    err_hit[ERR_OVERFLOW]   = fifo_push && fifo_full && !fifo_pop;
    err_hit[ERR_ISSUE_VIOL] = (pixel_issue && !issue_allow) || flush_bad;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
      pack_cnt <= 2'd0;
      pack_reg <= '0;
      err      <= 1'b0;
    end else begin
      if (pixel_issue && !result_datain_valid) begin
        inflight <= inflight + 1'b1;
      end else if (!pixel_issue && result_datain_valid && (inflight != '0)) begin
        inflight <= inflight - 1'b1;
      end
      // An overflowed word is simply not accepted by the FIFO; the packer still restarts.
      if (result_datain_valid) begin
        case (pack_cnt)
          2'd0:    pack_reg[7:0]   <= result_datain;
          2'd1:    pack_reg[15:8]  <= result_datain;
          2'd2:    pack_reg[23:16] <= result_datain;
          default: ;
        endcase
        pack_cnt <= (pack_cnt == 2'd3) ? 2'd0 : pack_cnt + 2'd1;
      end else if (flush_push) begin
        pack_cnt <= 2'd0;
      end
      if (|err_hit) err <= 1'b1;
    end
  end

  skintone_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(fifo_entry_t))
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fifo_push),
    .push_data  (push_entry),
    .pop        (fifo_pop),
    .head_data  (head_entry),
    .head_valid (fifo_valid),
    .full       (fifo_full),
    .count      (fifo_count)
  );

  assign word_dataout_valid = fifo_valid;
  assign word_dataout       = fifo_valid ? head_entry.data  : '0;
  assign word_bytes         = fifo_valid ? head_entry.bytes : '0;
  assign idle               = (inflight == '0) && (pack_cnt == 2'd0) && !fifo_valid;

endmodule

// File: tb/tb_skintone_result_collector.sv
// tb/tb_skintone_result_collector.sv - directed self-checking bench for skintone_result_collector
// Flush cases are compiled when SKINTONE_COLLECT_FLUSH_EN is defined.
module tb_skintone_result_collector;

  localparam int FIFO_DEPTH = 8;
  localparam int CNT_W      = 6;
  localparam int LAT        = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        pixel_issue;
  logic        issue_allow;
  logic [7:0]  result_datain;
  logic        result_datain_valid;
  logic        flush;
  logic [31:0] word_dataout;
  logic [2:0]  word_bytes;
  logic        word_dataout_valid;
  logic        word_dataout_ready;
  logic        idle;
  logic        err;

  always #5 clk = ~clk;

  skintone_result_collector #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .pixel_issue         (pixel_issue),
    .issue_allow         (issue_allow),
    .result_datain       (result_datain),
    .result_datain_valid (result_datain_valid),
    .flush               (flush),
    .word_dataout        (word_dataout),
    .word_bytes          (word_bytes),
    .word_dataout_valid  (word_dataout_valid),
    .word_dataout_ready  (word_dataout_ready),
    .idle                (idle),
    .err                 (err)
  );

  typedef struct {
    int         due;
    logic [7:0] b;
  } pend_t;

  typedef struct {
    logic        iss;
    logic        rv;
    logic [7:0]  rd;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_word;
    logic [2:0]  e_bytes;
    logic        e_allow;
    logic        e_idle;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          pops   = 0;
  int          mcnt   = 0;
  logic [31:0] mword  = '0;
  pend_t       pend[$];
  logic [31:0] exp_q[$];
  vec_t        tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    mword[mcnt*8 +: 8] = b;
    mcnt++;
    if (mcnt == 4) begin
      exp_q.push_back(mword);
      mcnt  = 0;
      mword = '0;
    end
  endtask

  // One clock of a feeder plus a fixed-latency datapath; pops are checked against the model.
  task automatic tick(input logic iss, input logic [7:0] b);
    pend_t pr;
    pixel_issue = iss;
    if (iss) begin
      pr.due = cyc + LAT;
      pr.b   = b;
      pend.push_back(pr);
    end
    if (pend.size() > 0 && pend[0].due == cyc) begin
      pr = pend.pop_front();
      result_datain       = pr.b;
      result_datain_valid = 1'b1;
      model_byte(pr.b);
    end else begin
      result_datain       = 8'h00;
      result_datain_valid = 1'b0;
    end
    if (word_dataout_valid && word_dataout_ready) begin
      if (exp_q.size() == 0) chk("pop_unexpected", 32'd1, 32'd0);
      else                   chk("pop_word", word_dataout, exp_q.pop_front());
      pops++;
    end
    @(posedge clk);
    #1;
    cyc++;
    pixel_issue         = 1'b0;
    result_datain_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst                 = 1'b1;
    pixel_issue         = 1'b0;
    result_datain       = 8'h00;
    result_datain_valid = 1'b0;
    flush               = 1'b0;
    word_dataout_ready  = 1'b0;
    pend.delete();
    exp_q.delete();
    mcnt  = 0;
    mword = '0;
    pops  = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int c0;
    int issues;
    int extra;

    rst                 = 1'b1;
    pixel_issue         = 1'b0;
    result_datain       = 8'h00;
    result_datain_valid = 1'b0;
    flush               = 1'b0;
    word_dataout_ready  = 1'b0;
    #1;
    chk("rst_valid", word_dataout_valid, 0);
    chk("rst_allow", issue_allow, 1);
    chk("rst_idle", idle, 1);
    chk("rst_word", word_dataout, 0);
    chk("rst_bytes", word_bytes, 0);
    chk("rst_err", err, 0);

    // Zero-latency table: issue 4, pack 4, pop; then overlapping issue/result.
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0,        3'd0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0,        3'd0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0,        3'd0, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0,        3'd0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 32'h0,        3'd0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 32'h0,        3'd0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 32'h0,        3'd0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 8'h44, 1'b0, 1'b1, 32'h44332211, 3'd4, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0,        3'd0, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0,        3'd0, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 32'h0,        3'd0, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 8'h02, 1'b0, 1'b0, 32'h0,        3'd0, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 32'h0,        3'd0, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 8'h04, 1'b0, 1'b1, 32'h04030201, 3'd4, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0,        3'd0, 1'b1, 1'b1};

    do_reset();
    for (int i = 0; i < 15; i++) begin
      pixel_issue         = tbl[i].iss;
      result_datain_valid = tbl[i].rv;
      result_datain       = tbl[i].rd;
      word_dataout_ready  = tbl[i].rdy;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_valid", i), word_dataout_valid, tbl[i].e_valid);
      chk($sformatf("tbl%0d_word", i), word_dataout, tbl[i].e_word);
      chk($sformatf("tbl%0d_bytes", i), word_bytes, tbl[i].e_bytes);
      chk($sformatf("tbl%0d_allow", i), issue_allow, tbl[i].e_allow);
      chk($sformatf("tbl%0d_idle", i), idle, tbl[i].e_idle);
      chk($sformatf("tbl%0d_err", i), err, 0);
    end

    // Datapath latency: valid appears right after the edge sampling 0x44.
    do_reset();
    c0 = cyc;
    tick(1'b1, 8'h11);
    tick(1'b1, 8'h22);
    tick(1'b1, 8'h33);
    tick(1'b1, 8'h44);
    for (int i = 0; i < 40; i++) begin
      if (word_dataout_valid) break;
      tick(1'b0, 8'h00);
    end
    chk("lat_edges", cyc - c0, LAT + 4);
    chk("lat_word", word_dataout, 32'h44332211);
    chk("lat_bytes", word_bytes, 4);
    word_dataout_ready = 1'b1;
    tick(1'b0, 8'h00);
    word_dataout_ready = 1'b0;
    chk("lat_pop_valid", word_dataout_valid, 0);
    chk("lat_pop_idle", idle, 1);
    chk("lat_pops", pops, 1);

    // Fill with no downstream ready: credits cap at 4*FIFO_DEPTH.
    do_reset();
    issues = 0;
    for (int i = 0; i < 200; i++) begin
      logic iss;
      iss = issue_allow;
      tick(iss, issues[7:0]);
      if (iss) issues++;
      if (word_dataout_valid && exp_q.size() > 0) chk("hold_word", word_dataout, exp_q[0]);
    end
    chk("fill_issues", issues, 4 * FIFO_DEPTH);
    chk("fill_allow", issue_allow, 0);
    chk("fill_err", err, 0);
    chk("fill_words", exp_q.size(), FIFO_DEPTH);
    chk("fill_head", word_dataout, 32'h03020100);

    // One pop frees exactly one word of credit.
    word_dataout_ready = 1'b1;
    tick(1'b0, 8'h00);
    word_dataout_ready = 1'b0;
    chk("one_pop", pops, 1);
    extra = 0;
    for (int i = 0; i < 100; i++) begin
      logic iss;
      iss = issue_allow;
      tick(iss, issues[7:0]);
      if (iss) begin
        issues++;
        extra++;
      end
    end
    chk("extra_issues", extra, 4);
    chk("extra_allow", issue_allow, 0);
    word_dataout_ready = 1'b1;
    for (int i = 0; i < 40; i++) tick(1'b0, 8'h00);
    word_dataout_ready = 1'b0;
    chk("drain_pops", pops, FIFO_DEPTH + 1);
    chk("drain_left", exp_q.size(), 0);
    chk("drain_idle", idle, 1);
    chk("drain_err", err, 0);

    // Steady stream: issue and result in the same cycle for 64 cycles.
    do_reset();
    word_dataout_ready = 1'b1;
    for (int i = 0; i < LAT + 64; i++) begin
      chk("stream_allow", issue_allow, 1);
      tick(1'b1, i[7:0]);
    end
    for (int i = 0; i < 30; i++) tick(1'b0, 8'h00);
    word_dataout_ready = 1'b0;
    chk("stream_pops", pops, (LAT + 64) / 4);
    chk("stream_err", err, 0);
    chk("stream_idle", idle, 1);

    do_reset();
    tick(1'b1, 8'hAA);
    tick(1'b1, 8'hBB);
    tick(1'b1, 8'hCC);
    for (int i = 0; i < LAT + 4; i++) tick(1'b0, 8'h00);
    flush = 1'b1;
    tick(1'b0, 8'h00);
    flush = 1'b0;
`ifdef SKINTONE_COLLECT_FLUSH_EN
    chk("flush_valid", word_dataout_valid, 1);
    chk("flush_word", word_dataout, 32'h00CCBBAA);
    chk("flush_bytes", word_bytes, 3);
    chk("flush_err", err, 0);
    tick(1'b1, 8'h01);
    tick(1'b1, 8'h02);
    flush = 1'b1;
    tick(1'b0, 8'h00);
    flush = 1'b0;
    chk("flush_bad_err", err, 1);
`else
    chk("noflush_valid", word_dataout_valid, 0);
    chk("noflush_err", err, 0);
    tick(1'b1, 8'hDD);
    for (int i = 0; i < LAT + 2; i++) tick(1'b0, 8'h00);
    chk("noflush_word", word_dataout, 32'hDDCCBBAA);
    chk("noflush_bytes", word_bytes, 4);
`endif

    // Underflow: error is flagged but the byte still packs.
    do_reset();
    result_datain       = 8'h5A;
    result_datain_valid = 1'b1;
    @(posedge clk);
    #1;
    result_datain_valid = 1'b0;
    chk("uf_err", err, 1);
    chk("uf_idle", idle, 0);
    chk("uf_allow", issue_allow, 1);
    for (int i = 0; i < 3; i++) begin
      result_datain       = 8'h6B + 8'(i * 17);
      result_datain_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    result_datain_valid = 1'b0;
    chk("uf_valid", word_dataout_valid, 1);
    chk("uf_word", word_dataout, 32'h8D7C6B5A);
    result_datain       = 8'h9E;
    result_datain_valid = 1'b1;
    @(posedge clk);
    #1;
    result_datain_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_valid", word_dataout_valid, 0);
    chk("arst_idle", idle, 1);
    chk("arst_err", err, 0);
    chk("arst_word", word_dataout, 0);
    chk("arst_bytes", word_bytes, 0);
    chk("arst_allow", issue_allow, 1);
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
